// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues sequential word fetches under a credit limit,
// queues returned {insn, pc} pairs and presents the head to register read.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_resp_valid,
    input  logic [31:0] i_imem_resp_data,
    output logic        o_valid,
    output logic [31:0] o_insn,
    output logic [31:0] o_pc
);
    localparam int          PW  = $clog2(DEPTH);
    localparam int          CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   q_insn [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic [PW-1:0] q_head, q_tail;
    logic [CW-1:0] count;
    logic [31:0]   pf_pc  [DEPTH];
    logic [PW-1:0] pf_head, pf_tail;
    logic [CW-1:0] in_flight, drop;

    logic [CW:0]   used;
    logic          req_fire, resp_fire, resp_keep, resp_drop, pop;
    logic [CW-1:0] in_flight_nx;

    // Handshakes: a request transfers on the cycle both o_imem_req_valid and
    // i_imem_req_ready are high; valid never depends on ready. Responses have
    // no backpressure and return in request order, one per valid cycle.
    // A slot in the queue is reserved for every outstanding request, so the
    // credit check alone guarantees a kept response always fits.
    assign used             = {1'b0, in_flight} + {1'b0, count};
    assign o_imem_req_valid = rst && !i_redirect && (used < (CW+1)'(DEPTH));
    assign o_imem_addr      = fetch_pc;
    assign req_fire         = o_imem_req_valid && i_imem_req_ready;
    assign resp_fire        = i_imem_resp_valid && (in_flight != '0);
    assign resp_drop        = resp_fire && (drop != '0);
    assign resp_keep        = resp_fire && (drop == '0);
    assign pop              = (count != '0) && !stall && !i_redirect;
    assign in_flight_nx     = in_flight + CW'(req_fire) - CW'(resp_fire);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc  <= RESET_PC;
            q_head    <= '0;
            q_tail    <= '0;
            count     <= '0;
            pf_head   <= '0;
            pf_tail   <= '0;
            in_flight <= '0;
            drop      <= '0;
        end else begin
            in_flight <= in_flight_nx;
            if (i_redirect) begin
                // Everything still outstanding after this edge belongs to the old path.
                fetch_pc <= {i_redirect_pc[31:2], 2'b00};
                q_head   <= '0;
                q_tail   <= '0;
                count    <= '0;
                pf_head  <= '0;
                pf_tail  <= '0;
                drop     <= in_flight_nx;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    pf_tail  <= pf_tail + PW'(1);
                end
                if (resp_keep) begin
                    pf_head <= pf_head + PW'(1);
                    q_tail  <= q_tail + PW'(1);
                end
                if (pop) begin
                    q_head <= q_head + PW'(1);
                end
                count <= count + CW'(resp_keep) - CW'(pop);
                if (resp_drop) begin
                    drop <= drop - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pf_pc[pf_tail] <= fetch_pc;
        end
        if (resp_keep && !i_redirect) begin
            q_insn[q_tail] <= i_imem_resp_data;
            q_pc[q_tail]   <= pf_pc[pf_head];
        end
    end

    assign o_valid = (count != '0);
    assign o_insn  = o_valid ? q_insn[q_head] : NOP;
    assign o_pc    = o_valid ? q_pc[q_head] : 32'h0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory model with variable latency, expected-pair
// queue fed from accepted requests, monitor comparing the consumed head.
module tb_fetch_stage;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready = 1'b1;
    logic [31:0] o_imem_addr;
    logic        i_imem_resp_valid = 1'b0;
    logic [31:0] i_imem_resp_data = '0;
    logic        o_valid;
    logic [31:0] o_insn;
    logic [31:0] o_pc;

    fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_imem_req_valid(o_imem_req_valid), .i_imem_req_ready(i_imem_req_ready),
        .o_imem_addr(o_imem_addr),
        .i_imem_resp_valid(i_imem_resp_valid), .i_imem_resp_data(i_imem_resp_data),
        .o_valid(o_valid), .o_insn(o_insn), .o_pc(o_pc)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];          // {pc, insn} expected at the head, oldest first
    logic [31:0] mem_q_addr[$];
    int          mem_q_due[$];
    int          mem_lat = 1;
    int          ready_pct = 100;
    logic        req_fire_s = 1'b0;
    logic        resp_s = 1'b0;
    logic [31:0] addr_s = '0;
    logic [31:0] exp_req_addr = RESET_PC;
    logic        prev_redirect = 1'b0;
    int          accepted_cnt = 0;
    int          pop_cnt = 0;
    int          first_req_cyc = -1;
    int          first_valid_cyc = -1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory model (driver) ----------------
    always @(posedge clk) begin
        #1;
        if (resp_s && mem_q_addr.size() > 0) begin
            void'(mem_q_addr.pop_front());
            void'(mem_q_due.pop_front());
        end
        if (req_fire_s) begin
            mem_q_addr.push_back(addr_s);
            mem_q_due.push_back(cyc + mem_lat - 1);
        end
        if (mem_q_addr.size() > 0 && mem_q_due[0] <= cyc) begin
            i_imem_resp_valid = 1'b1;
            i_imem_resp_data  = mem_word(mem_q_addr[0]);
        end else begin
            i_imem_resp_valid = 1'b0;
            i_imem_resp_data  = $urandom;
        end
        i_imem_req_ready = ($urandom_range(99) < ready_pct);
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        req_fire_s = o_imem_req_valid && i_imem_req_ready;
        addr_s     = o_imem_addr;
        resp_s     = i_imem_resp_valid;
        if (!rst) begin
            exp_q.delete();
            exp_req_addr    = RESET_PC;
            prev_redirect   = 1'b0;
            accepted_cnt    = 0;
            first_req_cyc   = -1;
            first_valid_cyc = -1;
        end else begin
            if (prev_redirect) check("valid_after_redirect", 32'(o_valid), 32'd0);
            if (i_redirect) check("req_during_redirect", 32'(o_imem_req_valid), 32'd0);
            if (o_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL head_unexpected: got pc %h, expected no valid head", o_pc);
                end else begin
                    check("head_pc", o_pc, exp_q[0][63:32]);
                    check("head_insn", o_insn, exp_q[0][31:0]);
                    if (!stall && !i_redirect) begin
                        void'(exp_q.pop_front());
                        pop_cnt++;
                    end
                end
            end else begin
                check("idle_insn", o_insn, NOP);
                check("idle_pc", o_pc, 32'h0);
            end
            if (req_fire_s) begin
                check("req_addr", o_imem_addr, exp_req_addr);
                exp_q.push_back({exp_req_addr, mem_word(exp_req_addr)});
                exp_req_addr += 32'd4;
                accepted_cnt++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
            end
            if (i_redirect) begin
                exp_q.delete();
                exp_req_addr = {i_redirect_pc[31:2], 2'b00};
            end
            prev_redirect = i_redirect;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        @(posedge clk); #1;
        i_redirect    = 1'b1;
        i_redirect_pc = pc;
        @(posedge clk); #1;
        i_redirect    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_o_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_o_insn"}, o_insn, NOP);
        check({tag, "_o_pc"}, o_pc, 32'h0);
        check({tag, "_req_valid"}, 32'(o_imem_req_valid), 32'd0);
    endtask

    task automatic release_reset();
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    task automatic throughput(input string tag);
        int p0;
        p0 = pop_cnt;
        cycles(10);
        check(tag, 32'(pop_cnt - p0), 32'd10);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        cycles(3);
        check_reset_outputs("reset");

        // streaming from reset, single-cycle memory
        release_reset();
        cycles(12);
        check("first_valid_latency", 32'(first_valid_cyc - first_req_cyc), 32'd2);
        throughput("throughput_lat1");

        // stall from the very start: queue fills, requests stop at DEPTH
        @(posedge clk); #3;
        rst = 1'b0;
        stall = 1'b1;
        cycles(3);
        release_reset();
        cycles(10);
        check("stall_accepted", 32'(accepted_cnt), 32'(DEPTH));
        check("stall_req_valid", 32'(o_imem_req_valid), 32'd0);
        check("stall_head_pc", o_pc, RESET_PC);
        stall = 1'b0;
        cycles(6);
        throughput("throughput_after_stall");

        // redirect colliding with a response and a pop; misaligned target
        do_redirect(32'h0000_0203);
        cycles(8);
        // wrap-around of the fetch address
        do_redirect(32'hFFFF_FFF0);
        cycles(10);

        // long-latency memory, redirect with requests outstanding
        mem_lat = 3;
        cycles(6);
        do_redirect(32'h0000_0100);
        cycles(15);
        mem_lat = 1;
        cycles(5);

        // asynchronous reset between edges mid-burst
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        cycles(5);
        release_reset();
        cycles(10);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (i % 250 == 0) begin
                mem_lat   = $urandom_range(3, 1);
                ready_pct = $urandom_range(100, 40);
            end
            stall         = ($urandom_range(99) < 30);
            i_redirect    = ($urandom_range(99) < 4);
            i_redirect_pc = $urandom;
        end
        @(posedge clk); #1;
        stall      = 1'b0;
        i_redirect = 1'b0;
        mem_lat    = 1;
        ready_pct  = 100;
        cycles(10);
        throughput("throughput_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
